recv_n_bytes: RTL and testbench

//  UART receive counterpart of the n-byte sender: deserialises UART frames from uart_rxd_i and

---
 rtl/recv_n_bytes.sv | 238 +++++++++++++++++++++++
 tb/tb_recv_n_bytes.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/recv_n_bytes.sv
// UART receiver that packs BYTE_NUM consecutive good bytes into one word, first byte in the MSB byte.
// Define RECV_PARITY_CHECK_EN for 11-bit frames with a parity check; otherwise frames are 8N1.
module recv_n_bytes #(
   parameter int CLK_FREQ     = 50,
   parameter int BAUD_RATE    = 9600,
   parameter int CHECK_SEL    = 1,
   parameter int BYTE_NUM     = 4,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  uart_rxd_i,
   output logic [8*BYTE_NUM-1:0] nbytes_data_in_o,
   output logic                  rx_nbytes_done_o,
   output logic                  rx_nbytes_busy_o,
   output logic                  parity_err_o,
   output logic                  frame_err_o,
   output logic                  rx_timeout_o
);
   localparam int BIT_CNT  = CLK_FREQ * 1_000_000 / BAUD_RATE;
   localparam int HALF_CNT = BIT_CNT / 2;
   localparam int IDLE_LIM = TIMEOUT_BITS * BIT_CNT;
   localparam int CW       = $clog2(BIT_CNT + 1);
   localparam int TW       = $clog2(IDLE_LIM + 1);
   localparam int NW       = $clog2(BYTE_NUM + 1);
   localparam int WW       = 8 * BYTE_NUM;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t          state_r, state_nxt_s;
   logic            rxd_meta_r, rxd_sync_r, rxd_prev_r;
   logic            fall_s;
   logic [CW-1:0]   bit_cnt_r;
   logic [2:0]      bit_idx_r;
   logic [7:0]      data_r;
   logic [NW-1:0]   byte_cnt_r;
   logic [WW-1:0]   shift_r, assembled_s, word_r;
   logic [TW-1:0]   idle_cnt_r;
   logic            bit_done_s, start_ok_s, data_smp_s, stop_smp_s;
   logic            frame_bad_s, par_bad_s, byte_good_s, timeout_s;
   logic            done_r, busy_r, perr_r, ferr_r, tout_r;

`ifdef RECV_PARITY_CHECK_EN
   localparam logic CHK_ODD = (CHECK_SEL != 0);
   logic par_smp_s;
   logic par_r;

   function automatic logic xor9(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   // Capture the received parity bit
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         par_r <= 1'b0;
      end else if (par_smp_s) begin
         par_r <= rxd_sync_r;
      end
   end
`else
   logic unused_check_sel_s;
   assign unused_check_sel_s = (CHECK_SEL != 0);
`endif

   // Falling edge only counts once the line has been seen high after reset or a bad stop bit
   assign fall_s = rxd_prev_r & ~rxd_sync_r;

   generate
      if (BYTE_NUM == 1) begin : g_single
         assign assembled_s = data_r;
      end else begin : g_multi
         assign assembled_s = {shift_r[WW-9:0], data_r};
      end
   endgenerate

   // Input synchroniser and FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rxd_meta_r <= 1'b0;
         rxd_sync_r <= 1'b0;
         rxd_prev_r <= 1'b0;
         state_r    <= S_IDLE;
      end else begin
         rxd_meta_r <= uart_rxd_i;
         rxd_sync_r <= rxd_meta_r;
         rxd_prev_r <= rxd_sync_r;
         state_r    <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE:   if (fall_s) state_nxt_s = S_START; else state_nxt_s = S_IDLE;
         S_START:  if (bit_done_s) state_nxt_s = rxd_sync_r ? S_IDLE : S_DATA; else state_nxt_s = S_START;
`ifdef RECV_PARITY_CHECK_EN
         S_DATA:   if (bit_done_s && bit_idx_r == 3'd7) state_nxt_s = S_PARITY; else state_nxt_s = S_DATA;
`else
         S_DATA:   if (bit_done_s && bit_idx_r == 3'd7) state_nxt_s = S_STOP; else state_nxt_s = S_DATA;
`endif
         S_PARITY: if (bit_done_s) state_nxt_s = S_STOP; else state_nxt_s = S_PARITY;
         S_STOP:   if (bit_done_s) state_nxt_s = S_IDLE; else state_nxt_s = S_STOP;
         default:  state_nxt_s = S_IDLE;
      endcase
   end

   // Sampling strobes: half a bit into START, then one full bit per later state
   always_comb begin
      bit_done_s = 1'b0;
      start_ok_s = 1'b0;
      data_smp_s = 1'b0;
      stop_smp_s = 1'b0;
`ifdef RECV_PARITY_CHECK_EN
      par_smp_s  = 1'b0;
`endif
      case (state_r)
         S_START: begin
            bit_done_s = (bit_cnt_r == CW'(HALF_CNT - 1));
            start_ok_s = bit_done_s & ~rxd_sync_r;
         end
         S_DATA: begin
            bit_done_s = (bit_cnt_r == CW'(BIT_CNT - 1));
            data_smp_s = bit_done_s;
         end
         S_PARITY: begin
            bit_done_s = (bit_cnt_r == CW'(BIT_CNT - 1));
`ifdef RECV_PARITY_CHECK_EN
            par_smp_s  = bit_done_s;
`endif
         end
         S_STOP: begin
            bit_done_s = (bit_cnt_r == CW'(BIT_CNT - 1));
            stop_smp_s = bit_done_s;
         end
         default: bit_done_s = 1'b0;
      endcase
   end

   // Byte verdict at the stop sample, frame error taking priority, plus idle expiry
   always_comb begin
      frame_bad_s = stop_smp_s & ~rxd_sync_r;
`ifdef RECV_PARITY_CHECK_EN
      par_bad_s   = stop_smp_s & rxd_sync_r & (xor9(data_r, par_r) != CHK_ODD);
`else
      par_bad_s   = 1'b0;
`endif
      byte_good_s = stop_smp_s & rxd_sync_r & ~par_bad_s;
      timeout_s   = (state_r == S_IDLE) && (byte_cnt_r != NW'(0)) && (idle_cnt_r == TW'(IDLE_LIM - 1));
   end

   // Bit timer and LSB-first deserialiser
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bit_cnt_r <= CW'(0);
         bit_idx_r <= 3'd0;
         data_r    <= 8'd0;
      end else begin
         if (state_r == S_IDLE || bit_done_s) bit_cnt_r <= CW'(0);
         else                                 bit_cnt_r <= bit_cnt_r + CW'(1);
         if (start_ok_s) begin
            bit_idx_r <= 3'd0;
         end else if (data_smp_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
            data_r    <= {rxd_sync_r, data_r[7:1]};
         end
      end
   end

   // Packet assembly, status pulses and busy flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         byte_cnt_r <= NW'(0);
         shift_r    <= {WW{1'b0}};
         word_r     <= {WW{1'b0}};
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
         perr_r     <= 1'b0;
         ferr_r     <= 1'b0;
         tout_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         perr_r <= 1'b0;
         ferr_r <= 1'b0;
         tout_r <= 1'b0;
         if (timeout_s) begin
            byte_cnt_r <= NW'(0);
            busy_r     <= 1'b0;
            tout_r     <= 1'b1;
         end else if (frame_bad_s) begin
            byte_cnt_r <= NW'(0);
            busy_r     <= 1'b0;
            ferr_r     <= 1'b1;
         end else if (par_bad_s) begin
            byte_cnt_r <= NW'(0);
            busy_r     <= 1'b0;
            perr_r     <= 1'b1;
         end else if (byte_good_s) begin
            if (byte_cnt_r == NW'(BYTE_NUM - 1)) begin
               word_r     <= assembled_s;
               done_r     <= 1'b1;
               busy_r     <= 1'b0;
               byte_cnt_r <= NW'(0);
            end else begin
               shift_r    <= assembled_s;
               byte_cnt_r <= byte_cnt_r + NW'(1);
            end
         end else if (start_ok_s) begin
            busy_r <= 1'b1;
         end
      end
   end

   // Inter-byte idle timer: runs only in IDLE with a partial packet, paused inside a frame
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idle_cnt_r <= TW'(0);
      end else if (byte_cnt_r == NW'(0) || start_ok_s || timeout_s) begin
         idle_cnt_r <= TW'(0);
      end else if (state_r == S_IDLE) begin
         idle_cnt_r <= idle_cnt_r + TW'(1);
      end
   end

   assign nbytes_data_in_o = word_r;
   assign rx_nbytes_done_o = done_r;
   assign rx_nbytes_busy_o = busy_r;
   assign parity_err_o     = perr_r;
   assign frame_err_o      = ferr_r;
   assign rx_timeout_o     = tout_r;

endmodule

// File: tb/tb_recv_n_bytes.sv
// Self-checking bench for recv_n_bytes: directed scenarios plus random frames against a packet-level model.
module tb_recv_n_bytes;
   localparam int BC    = 1 * 1_000_000 / 100000;
   localparam int HALF  = BC / 2;
   localparam int LIMIT = 20 * BC;
`ifdef RECV_PARITY_CHECK_EN
   localparam int FB     = 11;
   localparam bit PAR_EN = 1'b1;
`else
   localparam int FB     = 10;
   localparam bit PAR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rxd;
   logic [31:0] data;
   logic        done, busy, perr, ferr, tout;

   recv_n_bytes #(
      .CLK_FREQ(1), .BAUD_RATE(100000), .CHECK_SEL(1), .BYTE_NUM(4), .TIMEOUT_BITS(20)
   ) dut (
      .clk_i(clk), .rst_i(rst), .uart_rxd_i(rxd),
      .nbytes_data_in_o(data), .rx_nbytes_done_o(done), .rx_nbytes_busy_o(busy),
      .parity_err_o(perr), .frame_err_o(ferr), .rx_timeout_o(tout)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic rst_seen = 1'b1;
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   // One expected frame: cycle of start-bit verdict, cycle of stop verdict, byte, kind (0 good, 1 parity, 2 frame)
   typedef struct {
      int         e0;
      int         es;
      logic [7:0] b;
      int         kind;
   } ev_t;
   ev_t evq[$];

   int tests = 0;
   int fails = 0;
   int n_done = 0, n_perr = 0, n_ferr = 0, n_tout = 0;

   logic [31:0] m_sr, m_word;
   int          m_cnt, m_last;
   bit          m_busy, m_armed;
   bit          e_done, e_perr, e_ferr, e_tout;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Packet-level model and per-cycle compare
   initial begin
      forever begin
         @(negedge clk);
         e_done = 1'b0; e_perr = 1'b0; e_ferr = 1'b0; e_tout = 1'b0;
         if (rst_seen) begin
            m_sr = 32'h0; m_word = 32'h0; m_cnt = 0; m_busy = 1'b0; m_armed = 1'b0; m_last = 0;
            evq.delete();
         end else begin
            if (m_armed && m_cnt > 0 && cyc == m_last + LIMIT) begin
               e_tout = 1'b1; m_cnt = 0; m_busy = 1'b0; m_armed = 1'b0;
            end
            if (evq.size() > 0) begin
               if (evq[0].e0 == cyc) begin
                  m_busy  = 1'b1;
                  m_armed = 1'b0;
               end
               if (evq[0].es == cyc) begin
                  case (evq[0].kind)
                     2: begin e_ferr = 1'b1; m_cnt = 0; m_busy = 1'b0; end
                     1: begin e_perr = 1'b1; m_cnt = 0; m_busy = 1'b0; end
                     default: begin
                        m_sr  = {m_sr[23:0], evq[0].b};
                        m_cnt = m_cnt + 1;
                        if (m_cnt == 4) begin
                           m_word = m_sr; e_done = 1'b1; m_cnt = 0; m_busy = 1'b0;
                        end
                     end
                  endcase
                  m_last  = cyc;
                  m_armed = 1'b1;
                  evq.pop_front();
               end
            end
         end
         if (done === 1'b1) n_done++;
         if (perr === 1'b1) n_perr++;
         if (ferr === 1'b1) n_ferr++;
         if (tout === 1'b1) n_tout++;
         chk("word", data, m_word);
         chk("done", {31'b0, done}, {31'b0, e_done});
         chk("busy", {31'b0, busy}, {31'b0, m_busy});
         chk("parity_err", {31'b0, perr}, {31'b0, e_perr});
         chk("frame_err", {31'b0, ferr}, {31'b0, e_ferr});
         chk("timeout", {31'b0, tout}, {31'b0, e_tout});
      end
   end

   // All drive tasks start and end 1 time unit after a rising edge
   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit flip, input bit stopb, input int nbits);
      logic [10:0] fr;
      ev_t         ev;
      fr      = 11'h7FF;
      fr[0]   = 1'b0;
      fr[8:1] = b;
      if (PAR_EN) begin
         fr[9]  = (~^b) ^ flip;
         fr[10] = stopb;
      end else begin
         fr[9]  = stopb;
      end
      ev.e0   = cyc + 3 + HALF;
      ev.es   = cyc + 3 + HALF + (FB - 1) * BC;
      ev.b    = b;
      ev.kind = !stopb ? 2 : ((PAR_EN && flip) ? 1 : 0);
      evq.push_back(ev);
      for (int i = 0; i < nbits; i++) begin
         rxd = fr[i];
         repeat (BC) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic send_good(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, FB);
   endtask

   int d0, p0, f0, t0, r;
   logic [7:0] rb;

   initial begin
      rst = 1'b1;
      rxd = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(20);
      chk("reset_word", data, 32'h0);
      chk("reset_busy", {31'b0, busy}, 32'h0);

      // Back-to-back packet
      d0 = n_done;
      send_good(8'hDE); send_good(8'hAD); send_good(8'hBE); send_good(8'hEF);
      idle(5);
      chk("t1_word", data, 32'hDEADBEEF);
      chk("t1_model_word", m_word, 32'hDEADBEEF);
      chk("t1_done_count", n_done - d0, 32'd1);

`ifdef RECV_PARITY_CHECK_EN
      d0 = n_done; p0 = n_perr;
      send_good(8'h11);
      send_frame(8'h22, 1'b1, 1'b1, FB);
      idle(5);
      chk("t2_perr_count", n_perr - p0, 32'd1);
      chk("t2_done_count", n_done - d0, 32'd0);
      chk("t2_busy", {31'b0, busy}, 32'h0);
`endif
      send_good(8'h01); send_good(8'h02); send_good(8'h03); send_good(8'h04);
      idle(5);
      chk("t2_word", data, 32'h01020304);

      // Bad stop bit on the first byte, then a clean packet
      f0 = n_ferr; d0 = n_done;
      send_frame(8'hA5, 1'b0, 1'b0, FB);
      idle(30);
      chk("t3_ferr_count", n_ferr - f0, 32'd1);
      chk("t3_word_held", data, 32'h01020304);
      chk("t3_done_count", n_done - d0, 32'd0);
      send_good(8'h12); send_good(8'h34); send_good(8'h56); send_good(8'h78);
      idle(5);
      chk("t3_word", data, 32'h12345678);

      // Partial packet dropped on idle timeout
      t0 = n_tout;
      send_good(8'h55); send_good(8'hAA);
      idle(LIMIT + 30);
      chk("t4_tout_count", n_tout - t0, 32'd1);
      chk("t4_busy", {31'b0, busy}, 32'h0);
      send_good(8'hC0); send_good(8'hFF); send_good(8'hEE); send_good(8'h01);
      idle(5);
      chk("t4_word", data, 32'hC0FFEE01);

      // Short low glitch on an idle line
      d0 = n_done; p0 = n_perr; f0 = n_ferr; t0 = n_tout;
      rxd = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      idle(40);
      chk("t5_pulses", (n_done - d0) + (n_perr - p0) + (n_ferr - f0) + (n_tout - t0), 32'd0);
      chk("t5_busy", {31'b0, busy}, 32'h0);

      // Reset in the middle of the third byte
      send_good(8'h9A); send_good(8'hBC);
      send_frame(8'hDE, 1'b0, 1'b1, 4);
      rst = 1'b1;
      rxd = 1'b1;
      @(posedge clk); #1;
      chk("t6_word_reset", data, 32'h0);
      chk("t6_busy_reset", {31'b0, busy}, 32'h0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      idle(20);
      send_good(8'hCA); send_good(8'hFE); send_good(8'hF0); send_good(8'h0D);
      idle(5);
      chk("t6_word", data, 32'hCAFEF00D);

      // Random frames with injected errors and occasional long idles
      for (int i = 0; i < 60; i++) begin
         rb = 8'($urandom);
         r  = $urandom_range(0, 19);
         if (r == 0) begin
            send_frame(rb, 1'b0, 1'b0, FB);
            idle(2 * BC);
         end else if (r == 1) begin
            send_frame(rb, 1'b1, 1'b1, FB);
         end else begin
            send_good(rb);
         end
         r = $urandom_range(0, 19);
         if (r == 0) idle(LIMIT + 50);
         else        idle($urandom_range(0, 20));
      end
      idle(LIMIT + 20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
